// File: rtl/uart_pkg.sv
// Shared types and constants for the 64-bit UART word receiver.
package uart_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Clock cycles per bit time (integer division).
    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_recv_frame64_if.sv
// Serial input and received byte/word outputs of the 64-bit UART receiver.
interface uart_recv_frame64_if;

    logic        uart_rxd;
    logic        uart_done;
    logic [63:0] uart_data;
    logic        byte_done;
    logic [7:0]  byte_data;
    logic        frame_err;

    // Line driver / result consumer side.
    modport master (
        output uart_rxd,
        input  uart_done,
        input  uart_data,
        input  byte_done,
        input  byte_data,
        input  frame_err
    );

    // Receiver side.
    modport slave (
        input  uart_rxd,
        output uart_done,
        output uart_data,
        output byte_done,
        output byte_data,
        output frame_err
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, bit-timing FSM and byte/error pulses.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronized input
// START | counting to mid start bit; a high sample there is a glitch
// DATA  | sampling eight data bits at mid-bit, LSB first
// STOP  | sampling the stop bit at mid-bit, then straight back to IDLE
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic       byte_done_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output logic       start_o,
    output logic       idle_o,
    output logic       accept_o,
    output logic       error_o,
    output logic [7:0] accept_byte_o
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CNT_W   = $clog2(BPS_CNT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 1);

    rx_state_e        state_q, state_d;
    logic             rxd_m_q, rxd_s_q, rxd_d_q;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_done_q, byte_done_d;
    logic             frame_err_q, frame_err_d;
    logic             start_det, half_tick, bit_tick;

    assign start_det = (state_q == IDLE) && rxd_d_q && !rxd_s_q;
    assign half_tick = (clk_cnt_q == HALF_LAST);
    assign bit_tick  = (clk_cnt_q == BIT_LAST);

    // Two-flop synchronizer plus one delay flop for falling-edge detection; idle line is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
            rxd_d_q <= 1'b1;
        end else begin
            rxd_m_q <= rxd_i;
            rxd_s_q <= rxd_m_q;
            rxd_d_q <= rxd_s_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STOP returns to IDLE at mid-stop so back-to-back frames are caught.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_det) state_d = START;
            START:   if (half_tick) state_d = rxd_s_q ? IDLE : DATA;
            DATA:    if (bit_tick && (bit_cnt_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit timing, shift register and registered byte/error pulses.
    always_comb begin
        clk_cnt_d   = clk_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_data_d = byte_data_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            START: begin
                if (half_tick) clk_cnt_d = '0;
            end
            DATA: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    if (rxd_s_q) begin
                        byte_done_d = 1'b1;
                        byte_data_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: clk_cnt_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_data_q <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_data_q <= byte_data_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign byte_done_o   = byte_done_q;
    assign byte_data_o   = byte_data_q;
    assign frame_err_o   = frame_err_q;
    assign start_o       = start_det;
    assign idle_o        = (state_q == IDLE);
    // Stop-sample strobes: the word assembler registers on the same edge as byte_done.
    assign accept_o      = (state_q == STOP) && bit_tick && rxd_s_q;
    assign error_o       = (state_q == STOP) && bit_tick && !rxd_s_q;
    assign accept_byte_o = shift_q;

endmodule

// File: rtl/uart_recv_frame64.sv
// UART receiver that packs eight bytes (first byte in the MSBs) into a 64-bit word,
// with an inter-byte timeout that drops a partial word to re-align framing.
module uart_recv_frame64
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int UART_BPS     = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_recv_frame64_if.slave bus
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int TO_CYC  = TIMEOUT_BITS * BPS_CNT;
    localparam int IDLE_W  = $clog2(TO_CYC + 1);
    localparam int IDX_W   = $clog2(BYTES_PER_WORD);
    localparam logic [IDLE_W-1:0] TO_LAST   = IDLE_W'(TO_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] uart_data_q, uart_data_d;
    logic              uart_done_q, uart_done_d;
    logic              rx_start, rx_idle, rx_accept, rx_error;
    logic [7:0]        rx_byte;
    logic              timeout_hit;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_rx_byte (
        .clk_i         (sys_clk),
        .rst_i         (sys_rst),
        .rxd_i         (bus.uart_rxd),
        .byte_done_o   (bus.byte_done),
        .byte_data_o   (bus.byte_data),
        .frame_err_o   (bus.frame_err),
        .start_o       (rx_start),
        .idle_o        (rx_idle),
        .accept_o      (rx_accept),
        .error_o       (rx_error),
        .accept_byte_o (rx_byte)
    );

    assign timeout_hit = rx_idle && (byte_cnt_q != '0) && (idle_cnt_q == TO_LAST);

    // Word assembly, byte counter and idle timeout; a start on the timeout cycle still clears the count.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = '0;
        word_d      = word_q;
        uart_data_d = uart_data_q;
        uart_done_d = 1'b0;

        if (!rx_start && rx_idle && (byte_cnt_q != '0) && !timeout_hit) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end

        if (timeout_hit) byte_cnt_d = '0;

        if (rx_error) begin
            byte_cnt_d = '0;
        end else if (rx_accept) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (byte_cnt_q == IDX_W'(i)) word_d[WORD_W-1-8*i -: 8] = rx_byte;
            end
            if (byte_cnt_q == LAST_BYTE) begin
                uart_data_d = word_d;
                uart_done_d = 1'b1;
                byte_cnt_d  = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + IDX_W'(1);
            end
        end
    end

    // Word-level registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            word_q      <= '0;
            uart_data_q <= '0;
            uart_done_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            word_q      <= word_d;
            uart_data_q <= uart_data_d;
            uart_done_q <= uart_done_d;
        end
    end

    assign bus.uart_done = uart_done_q;
    assign bus.uart_data = uart_data_q;

endmodule

// File: tb/tb_uart_recv_frame64.sv
// Self-checking bench for uart_recv_frame64 at 10 clocks per bit, 200-cycle timeout.
module tb_uart_recv_frame64;

    localparam int CLK_FREQ     = 1_000_000;
    localparam int UART_BPS     = 100_000;
    localparam int TIMEOUT_BITS = 20;
    localparam int BPS          = CLK_FREQ / UART_BPS;
    localparam int TO_CYC       = TIMEOUT_BITS * BPS;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    uart_recv_frame64_if bus();

    uart_recv_frame64 #(
        .CLK_FREQ     (CLK_FREQ),
        .UART_BPS     (UART_BPS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    // Reference model state: what the line carried, reduced to expected events.
    logic [7:0]  partial[$];
    logic [7:0]  exp_bytes[$];
    logic [63:0] exp_words[$];
    int          exp_errs = 0;
    logic [63:0] exp_data = '0;
    logic [7:0]  exp_last_byte = '0;

    // Observed events.
    logic [7:0]  obs_bytes[$];
    logic [63:0] obs_words[$];
    int          obs_errs = 0;
    int          misalign = 0;
    int          last_bd_cyc = -1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (bus.byte_done) begin
            obs_bytes.push_back(bus.byte_data);
            last_bd_cyc = cyc;
        end
        if (bus.uart_done) begin
            obs_words.push_back(bus.uart_data);
            if (!bus.byte_done) misalign++;
        end
        if (bus.frame_err) obs_errs++;
    end

    task automatic hold(input logic v, input int n);
        bus.uart_rxd = v;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, output int fall_cyc);
        logic [63:0] w;
        fall_cyc = cyc;
        hold(1'b0, BPS);
        for (int i = 0; i < 8; i++) hold(b[i], BPS);
        hold(stop_ok, BPS);
        if (!stop_ok) hold(1'b1, BPS);
        if (stop_ok) begin
            exp_bytes.push_back(b);
            exp_last_byte = b;
            partial.push_back(b);
            if (partial.size() == 8) begin
                w = '0;
                foreach (partial[i]) w = {w[55:0], partial[i]};
                exp_words.push_back(w);
                exp_data = w;
                partial.delete();
            end
        end else begin
            exp_errs++;
            partial.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        int f;
        send_byte(b, 1'b1, f);
    endtask

    task automatic idle(input int n);
        hold(1'b1, n);
        if (n >= TO_CYC) partial.delete();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbytes"}, 64'(obs_bytes.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(obs_bytes[i]), 64'(exp_bytes[i]));
        chk({tag, "_nwords"}, 64'(obs_words.size()), 64'(exp_words.size()));
        for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), obs_words[i], exp_words[i]);
        chk({tag, "_errs"}, 64'(obs_errs), 64'(exp_errs));
        chk({tag, "_data"}, bus.uart_data, exp_data);
        chk({tag, "_bdata"}, 64'(bus.byte_data), 64'(exp_last_byte));
        obs_bytes.delete();
        exp_bytes.delete();
        obs_words.delete();
        exp_words.delete();
        obs_errs = 0;
        exp_errs = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        bus.uart_rxd = 1'b1;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_uart_done", 64'(bus.uart_done), 64'd0);
        chk("rst_uart_data", bus.uart_data, 64'd0);
        chk("rst_byte_done", 64'(bus.byte_done), 64'd0);
        chk("rst_byte_data", 64'(bus.byte_data), 64'd0);
        chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
        sys_rst = 1'b0;
        idle(20);

        // Single byte; line falls at cycle f, detection cycle T0 = f + 2 (two sync flops).
        send_byte(8'h55, 1'b1, f);
        chk("lat_0x55", 64'(last_bd_cyc), 64'(f + 2 + 96));
        idle(250);
        check_stream("s1");

        // Back-to-back word.
        send(8'h01); send(8'h23); send(8'h45); send(8'h67);
        send(8'h89); send(8'hAB); send(8'hCD); send(8'hEF);
        idle(20);
        chk("s2_word_lit", exp_data, 64'h0123_4567_89AB_CDEF);
        check_stream("s2");

        // Stop bit low, then a random good word.
        send_byte(8'hA5, 1'b0, f);
        idle(20);
        for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
        idle(20);
        check_stream("s3");

        // Partial word lost to timeout.
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
        idle(250);
        for (int i = 1; i <= 8; i++) send(8'(i * 8'h11));
        idle(20);
        chk("s4_word_lit", exp_data, 64'h1122_3344_5566_7788);
        check_stream("s4");

        // Short low glitch on an idle line.
        hold(1'b0, 3);
        idle(40);
        check_stream("s5");

        // Reset in the middle of byte 4.
        send(8'hC1); send(8'hC2); send(8'hC3);
        hold(1'b0, BPS);
        hold(1'b1, BPS);
        hold(1'b0, 15);
        sys_rst = 1'b1;
        hold(1'b1, 3);
        chk("s6_rst_data", bus.uart_data, 64'd0);
        chk("s6_rst_done", 64'(bus.uart_done), 64'd0);
        sys_rst = 1'b0;
        partial.delete();
        exp_data = '0;
        exp_last_byte = '0;
        idle(20);
        check_stream("s6a");
        for (int i = 0; i < 8; i++) send(8'(8'hF0 + i));
        idle(20);
        chk("s6_word_lit", exp_data, 64'hF0F1_F2F3_F4F5_F6F7);
        check_stream("s6b");

        // Random mix of good bytes, framing errors, short gaps and timeouts.
        for (int r = 0; r < 60; r++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            if (sel == 0) send_byte(8'($urandom_range(0, 255)), 1'b0, f);
            else          send(8'($urandom_range(0, 255)));
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      idle(200 + int'($urandom_range(0, 60)));
            else if (sel < 6)  idle(int'($urandom_range(1, 20)));
        end
        idle(20);
        check_stream("rnd");

        chk("done_align", 64'(misalign), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
